imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 1024, meaning the instruction memory size in bytes.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, meaning the byte address of the first loaded byte.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a load.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_valid  input  1  rx_data is valid.
REQ-008 rx_ready  output  1  the loader accepts rx_data this cycle.
REQ-009 mem_we  output  1  byte write strobe to the instruction memory.
REQ-010 mem_addr  output  32  byte address of the write.
REQ-011 mem_wdata  output  8  byte to write.
REQ-012 busy  output  1  a load is in progress; the core is held in reset while high.
REQ-013 done  output  1  the last load completed successfully.
REQ-014 error  output  1  the last load was aborted.

Function
REQ-015 The FSM SHALL have the states IDLE, LEN, DATA, CHK, DONE and ERR.
REQ-016 A byte SHALL transfer only in a cycle where rx_valid and rx_ready are both 1.
REQ-017 rx_ready SHALL be 1 in LEN, DATA and CHK, and 0 in all other states.
REQ-018 IDLE, DONE and ERR SHALL go to LEN on start, clearing done, error and the byte count.
REQ-019 start SHALL be ignored in LEN, DATA and CHK.
REQ-020 LEN SHALL accept 4 bytes forming the 32-bit length L, little-endian, with the first byte as bits [7:0].
REQ-021 After the 4th length byte, the FSM SHALL go to ERR if BASE_ADDR+L > MEM_SIZE (computed in 33 bits, no wrap).
REQ-022 Otherwise, after the 4th length byte, the FSM SHALL go to DONE (or CHK) if L==0, else to DATA.
REQ-023 The k-th accepted DATA byte (k from 0) SHALL cause mem_we=1 exactly one cycle later, with mem_addr=BASE_ADDR+k and mem_wdata equal to that byte.
REQ-024 mem_we SHALL be 0 in every other cycle.
REQ-025 Back-to-back DATA bytes SHALL produce back-to-back writes with no bubbles.
REQ-026 Successive bytes SHALL land at ascending addresses, so word n of the image reads back little-endian from BASE_ADDR+4n.
REQ-027 After the L-th DATA byte is accepted, the FSM SHALL go to CHK (or DONE) in the next cycle.
REQ-028 The final write SHALL still issue in the cycle after the L-th byte, while the FSM is already in CHK or DONE.
REQ-029 busy SHALL be 1 in LEN, DATA and CHK, and also in the final write cycle.
REQ-030 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR; both hold until the next start.
REQ-031 rx_valid deasserted mid-load SHALL stall the FSM indefinitely, with no timeout.

Reset
REQ-032 While rst_n=0, the state SHALL be IDLE, the length and count registers 0, and the checksum register 0.
REQ-033 While rst_n=0, rx_ready, mem_we, busy, done and error SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-034 Reset asserted mid-load SHALL abort immediately, with no further write, including a pending one-cycle-delayed write.

Configuration
REQ-035 Macro IMEM_LOADER_CHECKSUM_EN SHALL control whether the checksum feature is compiled in.
REQ-036 With IMEM_LOADER_CHECKSUM_EN defined, an 8-bit sum modulo 256 SHALL be kept over the DATA bytes.
REQ-037 With the macro defined, CHK SHALL accept one byte and go to DONE if that byte equals the sum, else to ERR.
REQ-038 With the macro defined, CHK SHALL also apply when L==0, where the expected checksum byte is 0x00.
REQ-039 Without the macro, the CHK state and the sum register SHALL be absent, and every CHK transition SHALL go directly to DONE.

Verification
REQ-040 Scenario: start, then bytes 08 00 00 00 13 05 10 00 93 05 20 00 -> writes at addresses 0..7 with data 13,05,10,00,93,05,20,00; a little-endian read at address 0 gives 0x00100513; done=1.
REQ-041 Scenario: length bytes 01 04 00 00 (L=1025) with MEM_SIZE=1024 -> ERR, error=1, no mem_we ever asserted.
REQ-042 Scenario: rx_valid toggled every other cycle during DATA -> each write follows its byte by exactly 1 cycle, and the write count equals L.
REQ-043 Scenario: rst_n pulsed low after the 2nd DATA byte -> exactly 1 write issued, busy=0, state IDLE; a new start then loads correctly from BASE_ADDR.
REQ-044 Scenario (macro defined): L=2 with data AA 55 and checksum FF -> done=1.
REQ-045 Scenario (macro defined): L=2 with data AA 55 and checksum FE -> error=1, with both data writes still issued.
REQ-046 Scenario: start asserted during DATA -> ignored, and the load completes normally.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port for imem_loader.
// The master modport is the loader side; the slave modport is the byte source / memory side.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a little-endian 32-bit length, then that many bytes, and writes them to instruction memory.
// Optional trailing checksum byte is compiled in with the IMEM_LOADER_CHECKSUM_EN macro.
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_AFTER = S_CHK;
`else
    localparam logic [2:0] S_AFTER = S_DONE;
`endif

    logic [2:0]  state;
    logic [31:0] len_q;
    logic [31:0] cnt_q;
    logic [1:0]  len_idx;
    logic        wr_pend;
    logic [31:0] addr_q;
    logic [7:0]  wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    logic        rx_ready_c;
    logic        xfer;
    logic [31:0] len_full;
    logic [32:0] end_addr;
    logic [31:0] cnt_next;

    always_comb begin
        rx_ready_c = 1'b0;
        case (state)
            S_LEN, S_DATA: rx_ready_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:         rx_ready_c = 1'b1;
`endif
            default:       rx_ready_c = 1'b0;
        endcase
    end

    // The image must fit: the bound is checked in 33 bits so a huge length cannot wrap past it.
    assign xfer     = bus.rx_valid & rx_ready_c;
    assign len_full = {bus.rx_data, len_q[23:0]};
    assign end_addr = {1'b0, BASE_ADDR} + {1'b0, len_full};
    assign cnt_next = cnt_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            len_idx <= '0;
            wr_pend <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            wr_pend <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state   <= S_LEN;
                        len_q   <= '0;
                        cnt_q   <= '0;
                        len_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len_q[{len_idx, 3'b000} +: 8] <= bus.rx_data;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'd3) begin
                            if (end_addr > {1'b0, MEM_SIZE})
                                state <= S_ERR;
                            else if (len_full == 32'd0)
                                state <= S_AFTER;
                            else
                                state <= S_DATA;
                        end
                    end
                end
                // Each byte is registered and written one cycle later, so the last write overlaps the next state.
                S_DATA: begin
                    if (xfer) begin
                        wr_pend <= 1'b1;
                        addr_q  <= BASE_ADDR + cnt_q;
                        wdata_q <= bus.rx_data;
                        cnt_q   <= cnt_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + bus.rx_data;
`endif
                        if (cnt_next == len_q)
                            state <= S_AFTER;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer)
                        state <= (bus.rx_data == sum_q) ? S_DONE : S_ERR;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_c;
    assign bus.mem_we    = wr_pend;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign busy  = rx_ready_c | wr_pend;
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are handed over and
// matched (address, data, cycle) when mem_we fires.
module tb_imem_loader;

    localparam int unsigned MEM  = 1024;
    localparam int unsigned BASE = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(
        .MEM_SIZE (MEM),
        .BASE_ADDR(BASE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .bus  (bus),
        .busy (busy),
        .done (done),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img[$];
    logic [7:0] tb_mem[0:MEM-1];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we === 1'b1) begin
            wr_cnt++;
            checkOutput("busy_on_write", {63'd0, busy}, 64'd1);
            if (exp_q.size() == 0) begin
                checkOutput("write_expected", {63'd0, bus.mem_we}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", {32'd0, bus.mem_addr}, {32'd0, e.addr});
                checkOutput("wr_data", {56'd0, bus.mem_wdata}, {56'd0, e.data});
                checkOutput("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (bus.mem_addr < MEM) tb_mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
    task automatic sendByte(input logic [7:0] b, input bit is_data, input logic [31:0] addr);
        bit ok = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.rx_ready) ok = 1'b1;
        end
        if (!ok) begin
            checkOutput("rx_ready_timeout", {63'd0, bus.rx_ready}, 64'd1);
            bus.rx_valid = 1'b0;
        end else begin
            if (is_data) exp_q.push_back('{addr, b, cyc + 1});
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendLength(input logic [31:0] len);
        for (int k = 0; k < 4; k++) sendByte(len[8*k +: 8], 1'b0, 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] len, input int gap, input int start_mid, input bit bad_chk);
        logic [7:0] sum = 8'd0;
        bit len_err;
        bit exp_err;
        int base_wr;
        len_err = (64'(BASE) + 64'(len)) > 64'(MEM);
        exp_err = len_err;
        base_wr = wr_cnt;
        pulseStart();
        checkOutput("start_done_clr", {63'd0, done}, 64'd0);
        checkOutput("start_err_clr", {63'd0, error}, 64'd0);
        checkOutput("start_busy", {63'd0, busy}, 64'd1);
        sendLength(len);
        if (len_err) begin
            checkOutput("len_err_flag", {63'd0, error}, 64'd1);
        end else begin
            for (int k = 0; k < int'(len); k++) begin
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                    checkOutput("busy_stall", {63'd0, busy}, 64'd1);
                end
                if (k == start_mid) start = 1'b1;
                sendByte(img[k], 1'b1, BASE + k);
                start = 1'b0;
                sum = sum + img[k];
            end
            if (len != 0) begin
                checkOutput("final_write_we", {63'd0, bus.mem_we}, 64'd1);
                checkOutput("final_write_busy", {63'd0, busy}, 64'd1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            sendByte(bad_chk ? sum - 8'd1 : sum, 1'b0, 32'd0);
            exp_err = bad_chk;
`else
            if (bad_chk) $display("[TB] checksum byte skipped in this build");
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("end_done", {63'd0, done}, {63'd0, !exp_err});
        checkOutput("end_error", {63'd0, error}, {63'd0, exp_err});
        checkOutput("end_busy", {63'd0, busy}, 64'd0);
        checkOutput("end_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("write_count", 64'(wr_cnt - base_wr), len_err ? 64'd0 : 64'(len));
    endtask

    task automatic checkIdleOutputs(input string phase);
        checkOutput({phase, "_rx_ready"}, {63'd0, bus.rx_ready}, 64'd0);
        checkOutput({phase, "_mem_we"}, {63'd0, bus.mem_we}, 64'd0);
        checkOutput({phase, "_busy"}, {63'd0, busy}, 64'd0);
        checkOutput({phase, "_done"}, {63'd0, done}, 64'd0);
        checkOutput({phase, "_error"}, {63'd0, error}, 64'd0);
        checkOutput({phase, "_mem_addr"}, {32'd0, bus.mem_addr}, 64'd0);
        checkOutput({phase, "_mem_wdata"}, {56'd0, bus.mem_wdata}, 64'd0);
    endtask

    task automatic randomImage(input int n);
        img.delete();
        for (int k = 0; k < n; k++) img.push_back(8'($urandom));
    endtask

    initial begin
        int base_wr;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("idle");

        $display("[TB] example program image");
        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        applyStimulus(32'd8, 0, -1, 1'b0);
        checkOutput("word0", {32'd0, tb_mem[BASE+3], tb_mem[BASE+2], tb_mem[BASE+1], tb_mem[BASE]}, 64'h00100513);
        checkOutput("word1", {32'd0, tb_mem[BASE+7], tb_mem[BASE+6], tb_mem[BASE+5], tb_mem[BASE+4]}, 64'h00200593);

        $display("[TB] oversize lengths");
        applyStimulus(32'd1025, 0, -1, 1'b0);
        applyStimulus(MEM - BASE + 1, 0, -1, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 0, -1, 1'b0);

        $display("[TB] image exactly filling memory");
        randomImage(MEM - BASE);
        applyStimulus(MEM - BASE, 0, -1, 1'b0);

        $display("[TB] rx_valid every other cycle");
        randomImage(6);
        applyStimulus(32'd6, 1, -1, 1'b0);

        $display("[TB] zero length");
        img.delete();
        applyStimulus(32'd0, 0, -1, 1'b0);

        $display("[TB] reset mid-load");
        randomImage(8);
        base_wr = wr_cnt;
        pulseStart();
        sendLength(32'd8);
        sendByte(img[0], 1'b1, BASE);
        sendByte(img[1], 1'b1, BASE + 1);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        checkOutput("midrst_writes", 64'(wr_cnt - base_wr), 64'd1);
        checkOutput("midrst_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_no_late_write", 64'(wr_cnt - base_wr), 64'd1);
        checkIdleOutputs("postrst");
        randomImage(5);
        applyStimulus(32'd5, 0, -1, 1'b0);

        $display("[TB] start during DATA");
        randomImage(4);
        applyStimulus(32'd4, 0, 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum good and bad");
        img = '{8'hAA, 8'h55};
        applyStimulus(32'd2, 0, -1, 1'b0);
        applyStimulus(32'd2, 0, -1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
